// File: rtl/shift_pkg.sv
// Shared definitions for the shifter self-test: direction codes, BIST FSM
// encoding and the golden shift function used by the reference model.
package shift_pkg;

   localparam logic        DIR_LEFT    = 1'b0;
   localparam logic        DIR_RIGHT   = 1'b1;
   localparam int unsigned SHIFT_MAX_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Computed at the widest supported width; callers keep the low WIDTH bits,
   // which gives the zero-filled truncating left shift and logical right shift.
   function automatic logic [SHIFT_MAX_W-1:0] expected_shift(
      input logic [SHIFT_MAX_W-1:0] a,
      input int unsigned            amt,
      input logic                   dir
   );
      return (dir == DIR_RIGHT) ? (a >> amt) : (a << amt);
   endfunction

endpackage

// File: rtl/shift_ref_model.sv
// Combinational golden model of the shifter, narrowed to WIDTH bits.
module shift_ref_model
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned AMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [AMT_W-1:0] amt_i,
   input  logic             dir_i,
   output logic [WIDTH-1:0] y_o
);

   logic [SHIFT_MAX_W-1:0] full;

   assign full = expected_shift(SHIFT_MAX_W'(a_i), 32'(amt_i), dir_i);
   assign y_o  = full[WIDTH-1:0];

   if (WIDTH < SHIFT_MAX_W) begin : g_trim
      logic unused_hi;
      assign unused_hi = ^full[SHIFT_MAX_W-1:WIDTH];
   end

endmodule

// File: rtl/shift_bist.sv
// Exhaustive self-test of the shift_gate shifter: walks every {dir,amt,A},
// compares Y with the golden model and records count and first failure.
module shift_bist
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned AMT_W  = $clog2(WIDTH),
   parameter int unsigned SETTLE = 1,
   parameter int unsigned CNT_W  = WIDTH + AMT_W + 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [CNT_W-1:0]         err_count,
   output logic                     fail_valid,
   output logic [AMT_W+WIDTH:0]     fail_vec,
   output logic [WIDTH-1:0]         fail_y,
   output logic [WIDTH-1:0]         sh_a,
   output logic [AMT_W-1:0]         sh_amt,
   output logic                     sh_dir,
   input  logic [WIDTH-1:0]         sh_y
);

   localparam int unsigned IDX_W = 1 + AMT_W + WIDTH;
   localparam int unsigned SET_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [SET_W-1:0] SETTLE_CNT = SET_W'(SETTLE);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic               fail_valid_q, fail_valid_d;
   logic [IDX_W-1:0]   fail_vec_q, fail_vec_d;
   logic [WIDTH-1:0]   fail_y_q, fail_y_d;
   logic [WIDTH-1:0]   expected;
   logic               mismatch;

   // Stimulus is a pure decode of the registered index, so it never glitches.
   assign sh_a   = idx_q[WIDTH-1:0];
   assign sh_amt = idx_q[WIDTH +: AMT_W];
   assign sh_dir = idx_q[IDX_W-1];

   shift_ref_model #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_ref (
      .a_i   (sh_a),
      .amt_i (sh_amt),
      .dir_i (sh_dir),
      .y_o   (expected)
   );

   assign mismatch = (sh_y != expected);

   always_comb begin
      // NOTE: each _d takes its _q value first, so no branch can infer a latch.
      state_d      = state_q;
      idx_d        = idx_q;
      settle_d     = settle_q;
      err_d        = err_q;
      fail_valid_d = fail_valid_q;
      fail_vec_d   = fail_vec_q;
      fail_y_d     = fail_y_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d      = RUN;
               idx_d        = '0;
               settle_d     = '0;
               err_d        = '0;
               fail_valid_d = 1'b0;
               fail_vec_d   = '0;
               fail_y_d     = '0;
            end
         end
         RUN: begin
            if (settle_q == SETTLE_CNT) begin
               if (mismatch) begin
                  if (err_q != '1) err_d = err_q + CNT_W'(1);
                  if (!fail_valid_q) begin
                     fail_valid_d = 1'b1;
                     fail_vec_d   = idx_q;
                     fail_y_d     = sh_y;
                  end
               end
               if (idx_q == '1) begin
                  state_d = DONE;
               end else begin
                  idx_d    = idx_q + IDX_W'(1);
                  settle_d = '0;
               end
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         settle_q     <= '0;
         err_q        <= '0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= '0;
         fail_y_q     <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         settle_q     <= settle_d;
         err_q        <= err_d;
         fail_valid_q <= fail_valid_d;
         fail_vec_q   <= fail_vec_d;
         fail_y_q     <= fail_y_d;
      end
   end

   assign busy       = (state_q == RUN);
   assign done       = (state_q == DONE);
   assign pass       = done && (err_q == '0);
   assign err_count  = err_q;
   assign fail_valid = fail_valid_q;
   assign fail_vec   = fail_vec_q;
   assign fail_y     = fail_y_q;

endmodule
